// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-async-RAM bus sequencer.
package mem_bus_pkg;

    localparam int DATA_W         = 32;
    localparam int DEFAULT_ADDR_W = 24;
    localparam int DEFAULT_RAM_AW = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } mem_state_t;

    function automatic int wait_cnt_w(input int wait_cyc);
        return $clog2(wait_cyc + 1);
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decode of one device window; zero latency, no flow control.
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int RAM_AW = DEFAULT_RAM_AW
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [ADDR_W-RAM_AW-1:0] base,
    output logic                     hit,
    output logic [RAM_AW-1:0]        ram_addr
);

    assign hit      = (addr[ADDR_W-1:RAM_AW] == base);
    assign ram_addr = addr[RAM_AW-1:0];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding CPU->RAM sequencer; hit ack WAIT_CYC+3 cycles after accept, miss ack after 1.
// No queuing: cpu_req is only sampled in IDLE, so the CPU is stalled by busy until its ack.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                         ADDR_W   = DEFAULT_ADDR_W,
    parameter int                         RAM_AW   = DEFAULT_RAM_AW,
    parameter logic [ADDR_W-RAM_AW-1:0]   RAM_BASE = '0,
    parameter int                         WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int               CNT_W    = wait_cnt_w(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        state;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
    logic [RAM_AW-1:0] dec_addr;

    mem_addr_decode #(
        .ADDR_W (ADDR_W),
        .RAM_AW (RAM_AW)
    ) u_dec (
        .addr     (cpu_addr),
        .base     (RAM_BASE),
        .hit      (hit),
        .ram_addr (dec_addr)
    );

    // All RAM pins are registered so en/rw/addr/din can only move on clean clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cnt       <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_rw    <= 1'b1;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        busy <= 1'b1;
                        we_q <= cpu_we;
                        if (hit) begin
                            // RAM pins only move on a hit; a miss leaves the RAM untouched.
                            ram_addr <= dec_addr;
                            ram_din  <= cpu_wdata;
                            ram_rw   <= ~cpu_we;
                            state    <= SETUP;
                        end else begin
                            cpu_err <= 1'b1;
                            cpu_ack <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                SETUP: begin
                    ram_en <= 1'b1;
                    cnt    <= CNT_LOAD;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        ram_en <= 1'b0;
                        if (!we_q) begin
                            cpu_rdata <= ram_dout;
                        end
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    ram_rw  <= 1'b1;
                    cpu_ack <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    busy    <= 1'b0;
                    cpu_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: byte-wide async RAM model, pin-stability monitor, scoreboard of responses.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int WAIT_CYC = 2;
    localparam int TMO      = 40;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          edge_rel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_err, busy, ram_en, ram_rw;
    logic [31:0] cpu_rdata, ram_din;
    logic [16:0] ram_addr;
    logic [31:0] ram_dout = '0;

    logic        req1 = 1'b0, ack1, err1, busy1, en1, rw1;
    logic [31:0] rdata1, din1;
    logic [16:0] addr1;
    logic [31:0] dout1 = '0;
    logic        req4 = 1'b0, ack4, err4, busy4, en4, rw4;
    logic [31:0] rdata4, din4;
    logic [16:0] addr4;
    logic [31:0] dout4 = '0;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   viol = 0;
    int   en_samples = 0;
    exp_t sb[$];

    logic [7:0] mem [0:131071];

    mem_bus_ctrl #(.ADDR_W(24), .RAM_AW(17), .RAM_BASE(7'h00), .WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .busy(busy), .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    mem_bus_ctrl #(.ADDR_W(24), .RAM_AW(17), .RAM_BASE(7'h00), .WAIT_CYC(1)) dut_w1 (
        .clk(clk), .reset(reset), .cpu_req(req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(ack1), .cpu_rdata(rdata1), .cpu_err(err1),
        .busy(busy1), .ram_en(en1), .ram_rw(rw1), .ram_addr(addr1), .ram_din(din1),
        .ram_dout(dout1)
    );

    mem_bus_ctrl #(.ADDR_W(24), .RAM_AW(17), .RAM_BASE(7'h00), .WAIT_CYC(4)) dut_w4 (
        .clk(clk), .reset(reset), .cpu_req(req4), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(ack4), .cpu_rdata(rdata4), .cpu_err(err4),
        .busy(busy4), .ram_en(en4), .ram_rw(rw4), .ram_addr(addr4), .ram_din(din4),
        .ram_dout(dout4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [16:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Big-endian byte RAM, level sensitive, 1 ns update delay.
    always @(ram_en or ram_rw or ram_addr or ram_din) begin
        #1;
        if (ram_en && !ram_rw) begin
            mem[ram_addr]         = ram_din[31:24];
            mem[ram_addr + 17'd1] = ram_din[23:16];
            mem[ram_addr + 17'd2] = ram_din[15:8];
            mem[ram_addr + 17'd3] = ram_din[7:0];
        end
        ram_dout = (ram_en && ram_rw) ? {mem[ram_addr], mem[ram_addr + 17'd1],
                                         mem[ram_addr + 17'd2], mem[ram_addr + 17'd3]} : 32'h0;
    end

    always @(en1 or rw1 or addr1) begin
        #1;
        dout1 = (en1 && rw1) ? pat(addr1) : 32'h0;
    end

    always @(en4 or rw4 or addr4) begin
        #1;
        dout4 = (en4 && rw4) ? pat(addr4) : 32'h0;
    end

    logic        p_en = 1'b0;
    logic        p_rw = 1'b1;
    logic [16:0] p_addr = '0;
    logic [31:0] p_din = '0;

    always @(negedge clk) begin
        if (!reset && (ram_en || p_en) &&
            (ram_addr !== p_addr || ram_rw !== p_rw || ram_din !== p_din))
            viol <= viol + 1;
        if (ram_en) en_samples <= en_samples + 1;
        p_en   <= ram_en;
        p_rw   <= ram_rw;
        p_addr <= ram_addr;
        p_din  <= ram_din;
    end

    task automatic issue(input logic we, input logic [23:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        c0        = cyc + 1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_ack(output bit got, output int rel);
        got = 1'b0;
        rel = -1;
        for (int i = 0; i < TMO && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                rel = cyc + 1 - c0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({ram_en, ram_rw, cpu_ack, cpu_err, busy} !== 5'b01000) begin
            mismatched++;
            $display("FAIL reset_ctrl: en/rw/ack/err/busy got %b want 01000",
                     {ram_en, ram_rw, cpu_ack, cpu_err, busy});
        end
        compared++;
        if (ram_addr !== 17'h0 || ram_din !== 32'h0 || cpu_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data: addr %h din %h rdata %h want all 0", ram_addr, ram_din, cpu_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        bit   got;
        int   rel;
        int   en0;
        exp_t e;
        sb.push_back(exp_t'{1'b0, 32'h0, WAIT_CYC + 3});
        issue(1'b1, 24'h000010, 32'hDEADBEEF);
        wait_ack(got, rel);
        e = sb.pop_front();
        compared++;
        if (!got || rel != e.edge_rel) begin
            mismatched++;
            $display("FAIL wr_ack_edge: got %0d (seen %0d) want %0d", rel, got, e.edge_rel);
        end
        compared++;
        if (cpu_err !== e.err || cpu_rdata !== e.rdata || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL wr_resp: err %b rdata %h busy %b want err %b rdata %h busy 1",
                     cpu_err, cpu_rdata, busy, e.err, e.rdata);
        end
        compared++;
        if ({mem[17'h10], mem[17'h11], mem[17'h12], mem[17'h13]} !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL wr_ram_bytes: got %h want deadbeef",
                     {mem[17'h10], mem[17'h11], mem[17'h12], mem[17'h13]});
        end
        en0 = en_samples;
        sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, WAIT_CYC + 3});
        issue(1'b0, 24'h000010, 32'h0);
        wait_ack(got, rel);
        e = sb.pop_front();
        compared++;
        if (!got || rel != e.edge_rel) begin
            mismatched++;
            $display("FAIL rd_ack_edge: got %0d (seen %0d) want %0d", rel, got, e.edge_rel);
        end
        compared++;
        if (cpu_err !== e.err || cpu_rdata !== e.rdata) begin
            mismatched++;
            $display("FAIL rd_resp: err %b rdata %h want err %b rdata %h", cpu_err, cpu_rdata, e.err, e.rdata);
        end
        compared++;
        if (en_samples - en0 != WAIT_CYC) begin
            mismatched++;
            $display("FAIL rd_en_cycles: got %0d want %0d", en_samples - en0, WAIT_CYC);
        end
    endtask

    task automatic test_miss;
        bit   got;
        int   rel;
        int   en0;
        exp_t e;
        en0 = en_samples;
        sb.push_back(exp_t'{1'b1, 32'hDEADBEEF, 1});
        issue(1'b0, 24'h020000, 32'h0);
        wait_ack(got, rel);
        e = sb.pop_front();
        compared++;
        if (!got || rel != e.edge_rel) begin
            mismatched++;
            $display("FAIL miss_ack_edge: got %0d (seen %0d) want %0d", rel, got, e.edge_rel);
        end
        compared++;
        if (cpu_err !== e.err || cpu_rdata !== e.rdata) begin
            mismatched++;
            $display("FAIL miss_resp: err %b rdata %h want err %b rdata %h", cpu_err, cpu_rdata, e.err, e.rdata);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (en_samples != en0 || busy !== 1'b0 || cpu_err !== 1'b0) begin
            mismatched++;
            $display("FAIL miss_no_access: en cycles %0d busy %b err %b want 0 0 0", en_samples - en0, busy, cpu_err);
        end
    endtask

    task automatic test_back_to_back;
        bit          got;
        int          rel;
        int          t[3];
        logic [31:0] wd[3];
        exp_t        e;
        wd[0] = 32'h11112222;
        wd[1] = 32'h33334444;
        wd[2] = 32'h55556666;
        @(posedge clk); #1;
        cpu_we    = 1'b1;
        cpu_addr  = 24'h0;
        cpu_wdata = wd[0];
        cpu_req   = 1'b1;
        c0        = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, 0});
            wait_ack(got, rel);
            t[k] = cyc;
            e = sb.pop_front();
            compared++;
            if (!got || cpu_err !== e.err || cpu_rdata !== e.rdata) begin
                mismatched++;
                $display("FAIL b2b_resp%0d: seen %0d err %b rdata %h want err %b rdata %h",
                         k, got, cpu_err, cpu_rdata, e.err, e.rdata);
            end
            if (k < 2) begin
                cpu_addr  = 24'(4 * (k + 1));
                cpu_wdata = wd[k + 1];
            end else begin
                cpu_req = 1'b0;
            end
        end
        compared++;
        if (t[1] - t[0] != WAIT_CYC + 4 || t[2] - t[1] != WAIT_CYC + 4) begin
            mismatched++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d", t[1] - t[0], t[2] - t[1], WAIT_CYC + 4);
        end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if ({mem[17'(4*k)], mem[17'(4*k+1)], mem[17'(4*k+2)], mem[17'(4*k+3)]} !== wd[k]) begin
                mismatched++;
                $display("FAIL b2b_ram%0d: got %h want %h", k,
                         {mem[17'(4*k)], mem[17'(4*k+1)], mem[17'(4*k+2)], mem[17'(4*k+3)]}, wd[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit   got;
        int   rel;
        bit   stray;
        exp_t e;
        issue(1'b1, 24'h000040, 32'hCAFEF00D);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (ram_en !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0 || ram_rw !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_state: en %b busy %b ack %b rw %b want 0 0 0 1", ram_en, busy, cpu_ack, ram_rw);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack) stray = 1'b1;
        end
        compared++;
        if (stray) begin
            mismatched++;
            $display("FAIL rst_mid_noack: ack seen %b want 0", stray);
        end
        compared++;
        if ({mem[17'h40], mem[17'h41], mem[17'h42], mem[17'h43]} !== 32'hCAFEF00D) begin
            mismatched++;
            $display("FAIL rst_mid_ram: got %h want cafef00d", {mem[17'h40], mem[17'h41], mem[17'h42], mem[17'h43]});
        end
        sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, WAIT_CYC + 3});
        issue(1'b0, 24'h000010, 32'h0);
        wait_ack(got, rel);
        e = sb.pop_front();
        compared++;
        if (!got || rel != e.edge_rel || cpu_err !== e.err || cpu_rdata !== e.rdata) begin
            mismatched++;
            $display("FAIL rst_mid_read: edge %0d err %b rdata %h want edge %0d err %b rdata %h",
                     rel, cpu_err, cpu_rdata, e.edge_rel, e.err, e.rdata);
        end
    endtask

    task automatic test_wait_variants;
        bit          got1, got4;
        int          rel1, rel4;
        logic [31:0] rd1, rd4;
        logic [1:0]  st1, st4;
        exp_t        e;
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        cpu_addr = 24'h012344;
        req1     = 1'b1;
        req4     = 1'b1;
        c0       = cyc + 1;
        sb.push_back(exp_t'{1'b0, pat(17'h12344), 4});
        sb.push_back(exp_t'{1'b0, pat(17'h12344), 7});
        @(posedge clk); #1;
        req1 = 1'b0;
        req4 = 1'b0;
        got1 = 1'b0; got4 = 1'b0; rel1 = -1; rel4 = -1;
        rd1 = '0; rd4 = '0; st1 = '0; st4 = '0;
        for (int i = 0; i < TMO && !(got1 && got4); i++) begin
            @(negedge clk);
            if (ack1 && !got1) begin
                got1 = 1'b1; rel1 = cyc + 1 - c0; rd1 = rdata1; st1 = {err1, busy1};
            end
            if (ack4 && !got4) begin
                got4 = 1'b1; rel4 = cyc + 1 - c0; rd4 = rdata4; st4 = {err4, busy4};
            end
        end
        e = sb.pop_front();
        compared++;
        if (!got1 || rel1 != e.edge_rel || rd1 !== e.rdata || st1 !== {e.err, 1'b1}) begin
            mismatched++;
            $display("FAIL wait1_read: edge %0d rdata %h err/busy %b want edge %0d rdata %h", rel1, rd1, st1, e.edge_rel, e.rdata);
        end
        e = sb.pop_front();
        compared++;
        if (!got4 || rel4 != e.edge_rel || rd4 !== e.rdata || st4 !== {e.err, 1'b1}) begin
            mismatched++;
            $display("FAIL wait4_read: edge %0d rdata %h err/busy %b want edge %0d rdata %h", rel4, rd4, st4, e.edge_rel, e.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_miss();
        test_back_to_back();
        test_reset_mid();
        test_wait_variants();
        @(negedge clk);
        compared++;
        if (viol != 0) begin
            mismatched++;
            $display("FAIL pin_stability: %0d changes while ram_en high, want 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Synchronous bus sequencer between the CPU memory port and the asynchronous 128K×32 RAM. It accepts one request at a time from the CPU through a req/ack handshake and decodes the 24-bit address against the RAM window. It then drives the RAM's level-sensitive en/rw/addr/dataIn pins in a glitch-free setup → access → hold sequence, and returns read data or an error. It is the only driver of the RAM control pins.

## Interface
- `ADDR_W`, 24: CPU address width.
- `RAM_AW`, 17: RAM address width.
- `RAM_BASE`, 7'h00: required value of `cpu_addr[ADDR_W-1:RAM_AW]` for a RAM hit.
- `WAIT_CYC`, 2: clock cycles `ram_en` stays high per access; legal range ≥1.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: request; sampled only in IDLE.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: byte address of a 4-byte access.
- `cpu_wdata` in 32: write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data; valid when `cpu_ack`=1, held until the next read completes.
- `cpu_err` out 1: qualifies `cpu_ack`; 1 = decode miss, no RAM access performed.
- `busy` out 1: high from acceptance through the ack cycle.
- `ram_en` out 1: RAM enable.
- `ram_rw` out 1: 1 = read, 0 = write (RAM convention).
- `ram_addr` out RAM_AW: `cpu_addr[RAM_AW-1:0]`.
- `ram_din` out 32: write data to RAM.
- `ram_dout` in 32: RAM read bus; tri-stated by the RAM when not reading.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE, `cpu_req`=1: latch we/addr/wdata and set `busy`.
  - Decode hit → SETUP.
  - Miss → RESP with err=1.
- SETUP (1 cycle): drive `ram_addr`, `ram_din`, `ram_rw`=~we with `ram_en`=0. Load the wait counter with WAIT_CYC-1 → ACCESS.
- ACCESS (WAIT_CYC cycles): `ram_en`=1, with addr/rw/din stable. Counter decrements each cycle. At count 0, on a read, capture `ram_dout` into `cpu_rdata` → HOLD.
- HOLD (1 cycle): `ram_en`=0, addr/rw/din unchanged → RESP.
- RESP (1 cycle): `cpu_ack`=1, `cpu_err` valid → IDLE, `busy`=0. After HOLD/RESP, `ram_rw` returns to 1 with `ram_en` low.
- Invariant: addr, din and rw never change while `ram_en`=1. The RAM acts on any change of en/rw/addr.
- Requests are sampled only in IDLE. `cpu_req` held high after ack starts a new transaction on the next IDLE cycle; inputs are not re-read mid-transaction.
- Writes never modify `cpu_rdata`. An error response leaves `cpu_rdata` unchanged.
- Addresses are not alignment-checked. RAM wrap at `addr+3` beyond 2^17-1 is the RAM's behaviour.

## Timing
- Reset values: state IDLE, `ram_en`=0, `ram_rw`=1, `ram_addr`=0, `ram_din`=0, `cpu_ack`=0, `cpu_err`=0, `cpu_rdata`=0, `busy`=0.
- Request accepted at edge 0. RAM hit: `ram_en` high at edges 2..WAIT_CYC+1, `cpu_ack` at edge WAIT_CYC+3; with the default, ack at edge 5.
- Miss: ack+err at edge 1 (IDLE → RESP).
- Back-to-back minimum spacing: WAIT_CYC+4 cycles between acceptances for hits, 2 for misses.
- Reset mid-transaction: all outputs take reset values at that edge; `ram_en` falls immediately, and no ack is issued.
  - A write whose `ram_en` already rose is complete in RAM; the controller makes no guarantee beyond that.
- Read capture happens on the last ACCESS edge, at least one full cycle after `ram_en` rose (covers the RAM's 1 ns update delay). The clock period must exceed 1 ns.

## Structure
- Package `mem_bus_pkg`:
  - state enum `mem_state_t` (IDLE, SETUP, ACCESS, HOLD, RESP);
  - constants `DATA_W`=32, default `ADDR_W` and `RAM_AW`;
  - helper function for wait-counter width, `$clog2(WAIT_CYC+1)`.
- One sub-module is natural: `mem_addr_decode`, combinational, (addr, RAM_BASE) → hit and ram_addr. It is reused when further devices are mapped.
- Everything else stays in a single FSM plus datapath registers.

## Test plan
- Write 0xDEADBEEF to 0x000010, then read 0x000010 → ack at edge 5 each, err=0, rdata=0xDEADBEEF; RAM bytes 0x10..0x13 = DE AD BE EF.
- Read 0x020000 with RAM_BASE=0 → ack+err at edge 1, `ram_en` never rises, rdata unchanged.
- Monitor every change of `ram_addr`/`ram_rw`/`ram_din` → none occur while `ram_en`=1; `ram_en` is low ≥1 cycle between back-to-back accesses.
- `cpu_req` held high for 3 writes to 0x0, 0x4, 0x8 → three acks, spaced WAIT_CYC+4 cycles; RAM holds all three words.
- Assert `reset` at edge 3 of a write → next cycle `ram_en`=0, busy=0, no ack; a subsequent read completes normally.
- WAIT_CYC=1 and WAIT_CYC=4 builds → read ack at edges 4 and 7 with correct data.
